// File: rtl/io_pkg.sv
// Shared FSM state type and default widths for the pushbutton operand input path.
package io_pkg;

    localparam int SW_WIDTH_DEF   = 15;
    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_PRESSED = 2'd2,
        ST_HOLD    = 2'd3
    } io_state_e;

endpackage

// File: rtl/input_debouncer.sv
// Pushbutton conditioning: 2-flop synchronizer, optional stable-count debounce, edge pulses.
// INPUT_DEBOUNCE_EN selects the debounce counter; otherwise the synchronized level is used directly.
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_n,
    output logic level,
    output logic press_evt,
    output logic release_evt
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic level_prev_q, level_prev_d;
    logic btn;

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
        $error("input_debouncer: DEBOUNCE_CYCLES must be at least 1");
    end

    assign sync1_d = raw_n;
    assign sync2_d = sync1_q;
    assign btn     = ~sync2_q;

    // Synchronizer resets to the released (high) level so reset never looks like a press.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

`ifdef INPUT_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (btn != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = btn;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
`else
    assign level = btn;
`endif

    assign level_prev_d = level;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_prev_q <= 1'b0;
        end else begin
            level_prev_q <= level_prev_d;
        end
    end

    assign press_evt   =  level & ~level_prev_q;
    assign release_evt = ~level &  level_prev_q;

endmodule

// File: rtl/input_controller.sv
// Operand input controller: waits for a processor request, captures the switch bank on a
// debounced button press and holds it until acknowledged. Debounce enabled by INPUT_DEBOUNCE_EN.
//
//   state      | meaning
//   -----------+--------------------------------------------------------------
//   ST_IDLE    | no request pending; button events ignored
//   ST_ARMED   | request pending, LED on, waiting for a fresh press
//   ST_PRESSED | operand captured, waiting for the button to be released
//   ST_HOLD    | operand valid, waiting for the processor ack
module input_controller
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SW_WIDTH        = SW_WIDTH_DEF,
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enter,
    input  logic [SW_WIDTH-1:0]   switches,
    input  logic                  req,
    input  logic                  ack,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  waiting
);

    io_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  btn_level;
    logic                  press_evt;
    logic                  release_evt;

    input_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock       (clock),
        .reset       (reset),
        .raw_n       (enter),
        .level       (btn_level),
        .press_evt   (press_evt),
        .release_evt (release_evt)
    );

    // A press only counts if it happens while armed, so a button held across req rising
    // never produces a capture.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (req) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (press_evt && btn_level) begin
                    state_d = ST_PRESSED;
                    data_d  = DATA_WIDTH'($signed(switches));
                end
            end
            ST_PRESSED: begin
                if (release_evt) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign data    = data_q;
    assign valid   = (state_q == ST_HOLD);
    assign waiting = (state_q == ST_ARMED) || (state_q == ST_PRESSED);

endmodule
